// File: rtl/imm_gen_pkg.sv
// Shared types and opcode constants for the pipelined immediate generator.
// Optional CSR uimm decoding is enabled by defining IMM_GEN_ZIMM_EN.
package imm_gen_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5,
        FMT_Z = 3'd6
    } imm_fmt_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

endpackage

// File: rtl/imm_decode.sv
// Combinational instruction -> {immediate, format} decode, sign-extended to XLEN.
// IMM_GEN_ZIMM_EN: SYSTEM with funct3[2]=1 yields zero-extended rs1 field as format Z.
module imm_decode
    import imm_gen_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     ir_i,
    output logic [XLEN-1:0] imm_o,
    output imm_fmt_t        fmt_o
);

    logic [31:0] raw;

    always_comb begin
        raw   = '0;
        fmt_o = FMT_R;
        case (ir_i[6:0])
            OPC_LUI, OPC_AUIPC: begin
                fmt_o = FMT_U;
                raw   = {ir_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                fmt_o = FMT_J;
                raw   = {{11{ir_i[31]}}, ir_i[31], ir_i[19:12], ir_i[20], ir_i[30:21], 1'b0};
            end
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                fmt_o = FMT_I;
                raw   = {{20{ir_i[31]}}, ir_i[31:20]};
            end
            OPC_SYSTEM: begin
`ifdef IMM_GEN_ZIMM_EN
                if (ir_i[14]) begin
                    // bit 31 clear, so the sign extension below becomes a zero extension
                    fmt_o = FMT_Z;
                    raw   = {27'b0, ir_i[19:15]};
                end else begin
                    fmt_o = FMT_I;
                    raw   = {{20{ir_i[31]}}, ir_i[31:20]};
                end
`else
                fmt_o = FMT_I;
                raw   = {{20{ir_i[31]}}, ir_i[31:20]};
`endif
            end
            OPC_STORE: begin
                fmt_o = FMT_S;
                raw   = {{20{ir_i[31]}}, ir_i[31:25], ir_i[11:7]};
            end
            OPC_BRANCH: begin
                fmt_o = FMT_B;
                raw   = {{19{ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};
            end
            default: begin
                fmt_o = FMT_R;
                raw   = '0;
            end
        endcase
    end

    assign imm_o = XLEN'($signed(raw));

endmodule

// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer; latency 1, full throughput.
// IN_READY drops only when both entries are held. Optional: IMM_GEN_ZIMM_EN (CSR uimm, format Z).
module imm_gen_pipe
    import imm_gen_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter bit PASS_IR = 1'b1
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            IN_VALID,
    output logic            IN_READY,
    input  logic [31:0]     IR_INPUT,
    output logic            OUT_VALID,
    input  logic            OUT_READY,
    output logic [XLEN-1:0] IMM_OUT,
    output imm_fmt_t        IMM_FMT,
    output logic [31:0]     IR_OUT
);

    logic [XLEN-1:0] dec_imm;
    imm_fmt_t        dec_fmt;
    logic [31:0]     ir_in;

    imm_decode #(.XLEN(XLEN)) u_decode (
        .ir_i  (IR_INPUT),
        .imm_o (dec_imm),
        .fmt_o (dec_fmt)
    );

    assign ir_in = PASS_IR ? IR_INPUT : 32'h0;

    skid_state_t     state_q;
    logic            in_ready_q;
    logic            out_valid_q;
    // Entry 0 is the output register (oldest); entry 1 only fills under backpressure.
    logic [XLEN-1:0] imm0_q, imm1_q;
    imm_fmt_t        fmt0_q, fmt1_q;
    logic [31:0]     ir0_q,  ir1_q;

    logic in_xfer, out_xfer;
    assign in_xfer  = IN_VALID  & in_ready_q;
    assign out_xfer = out_valid_q & OUT_READY;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= ST_EMPTY;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            imm0_q      <= '0;
            fmt0_q      <= FMT_R;
            ir0_q       <= '0;
            imm1_q      <= '0;
            fmt1_q      <= FMT_R;
            ir1_q       <= '0;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_xfer) begin
                        imm0_q      <= dec_imm;
                        fmt0_q      <= dec_fmt;
                        ir0_q       <= ir_in;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_xfer && out_xfer) begin
                        imm0_q <= dec_imm;
                        fmt0_q <= dec_fmt;
                        ir0_q  <= ir_in;
                    end else if (in_xfer) begin
                        imm1_q     <= dec_imm;
                        fmt1_q     <= dec_fmt;
                        ir1_q      <= ir_in;
                        in_ready_q <= 1'b0;
                        state_q    <= ST_FULL;
                    end else if (out_xfer) begin
                        out_valid_q <= 1'b0;
                        state_q     <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_xfer) begin
                        imm0_q     <= imm1_q;
                        fmt0_q     <= fmt1_q;
                        ir0_q      <= ir1_q;
                        in_ready_q <= 1'b1;
                        state_q    <= ST_ONE;
                    end
                end
                default: begin
                    state_q     <= ST_EMPTY;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign IMM_OUT   = imm0_q;
    assign IMM_FMT   = fmt0_q;
    assign IR_OUT    = ir0_q;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit instance (IR passed) and a 64-bit instance (IR tied off)
// share stimulus and are scored against an arithmetic immediate model and a FIFO queue.
module tb_imm_gen_pipe;
    import imm_gen_pkg::*;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        IN_VALID;
    logic [31:0] IR_INPUT;
    logic        OUT_READY;

    logic        in_ready32, out_valid32;
    logic [31:0] imm32;
    logic [2:0]  fmt32;
    logic [31:0] ir_out32;

    logic        in_ready64, out_valid64;
    logic [63:0] imm64;
    logic [2:0]  fmt64;
    logic [31:0] ir_out64;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [63:0] imm;
        logic [2:0]  fmt;
        logic [31:0] ir;
    } exp_t;

    exp_t q[$];

    always #5 CLK = ~CLK;

    imm_gen_pipe #(.XLEN(32), .PASS_IR(1'b1)) dut32 (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(in_ready32),
        .IR_INPUT(IR_INPUT), .OUT_VALID(out_valid32), .OUT_READY(OUT_READY),
        .IMM_OUT(imm32), .IMM_FMT(fmt32), .IR_OUT(ir_out32)
    );

    imm_gen_pipe #(.XLEN(64), .PASS_IR(1'b0)) dut64 (
        .CLK(CLK), .RST_N(RST_N), .IN_VALID(IN_VALID), .IN_READY(in_ready64),
        .IR_INPUT(IR_INPUT), .OUT_VALID(out_valid64), .OUT_READY(OUT_READY),
        .IMM_OUT(imm64), .IMM_FMT(fmt64), .IR_OUT(ir_out64)
    );

    // Immediate value computed as a signed integer from the field weights.
    function automatic logic [63:0] ref_imm(input logic [31:0] ir, output logic [2:0] f);
        longint v;
        longint s;
        s = longint'($signed(ir));
        v = 0;
        f = 3'd0;
        case (ir[6:0])
            7'h37, 7'h17: begin f = 3'd4; v = (s >>> 12) * 4096; end
            7'h6F: begin
                f = 3'd5;
                v = (ir[31] ? -longint'(1 << 20) : 0) + longint'(ir[19:12]) * 4096
                    + longint'(ir[20]) * 2048 + longint'(ir[30:21]) * 2;
            end
            7'h67, 7'h03, 7'h13: begin f = 3'd1; v = s >>> 20; end
            7'h73: begin
`ifdef IMM_GEN_ZIMM_EN
                if (ir[14]) begin f = 3'd6; v = longint'(ir[19:15]); end
                else begin f = 3'd1; v = s >>> 20; end
`else
                f = 3'd1; v = s >>> 20;
`endif
            end
            7'h23: begin f = 3'd2; v = (s >>> 25) * 32 + longint'(ir[11:7]); end
            7'h63: begin
                f = 3'd3;
                v = (ir[31] ? -longint'(4096) : 0) + longint'(ir[7]) * 2048
                    + longint'(ir[30:25]) * 32 + longint'(ir[11:8]) * 2;
            end
            default: begin f = 3'd0; v = 0; end
        endcase
        return v;
    endfunction

    // One clock: drive inputs at the falling edge, score outputs, update the model at the rising edge.
    task automatic step(input bit iv, input logic [31:0] ir, input bit ordy);
        bit   acc, pop;
        exp_t e;
        IN_VALID  = iv;
        IR_INPUT  = ir;
        OUT_READY = ordy;
        #1;
        total++;
        if (out_valid32 !== (q.size() != 0) || out_valid64 !== (q.size() != 0)) begin
            bad++;
            $display("FAIL out_valid: got %b/%b want %b", out_valid32, out_valid64, q.size() != 0);
        end
        total++;
        if (in_ready32 !== (q.size() < 2) || in_ready64 !== (q.size() < 2)) begin
            bad++;
            $display("FAIL in_ready: got %b/%b want %b", in_ready32, in_ready64, q.size() < 2);
        end
        if (q.size() != 0) begin
            e = q[0];
            total++;
            if (imm32 !== e.imm[31:0] || fmt32 !== e.fmt || ir_out32 !== e.ir) begin
                bad++;
                $display("FAIL data32: got imm=%h fmt=%0d ir=%h want imm=%h fmt=%0d ir=%h",
                         imm32, fmt32, ir_out32, e.imm[31:0], e.fmt, e.ir);
            end
            total++;
            if (imm64 !== e.imm || fmt64 !== e.fmt || ir_out64 !== 32'h0) begin
                bad++;
                $display("FAIL data64: got imm=%h fmt=%0d ir=%h want imm=%h fmt=%0d ir=0",
                         imm64, fmt64, ir_out64, e.imm, e.fmt);
            end
        end
        acc = iv && (q.size() < 2);
        pop = (q.size() != 0) && ordy;
        @(posedge CLK);
        if (pop) void'(q.pop_front());
        if (acc) begin
            e.ir  = ir;
            e.imm = ref_imm(ir, e.fmt);
            q.push_back(e);
        end
        @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string name);
        #1;
        total++;
        if (out_valid32 !== 1'b0 || in_ready32 !== 1'b1 || imm32 !== 32'h0 || fmt32 !== 3'd0 ||
            ir_out32 !== 32'h0 || out_valid64 !== 1'b0 || in_ready64 !== 1'b1 || imm64 !== 64'h0) begin
            bad++;
            $display("FAIL %s: got ov=%b ir=%b imm=%h fmt=%0d irout=%h imm64=%h want 0,1,0,0,0,0",
                     name, out_valid32, in_ready32, imm32, fmt32, ir_out32, imm64);
        end
    endtask

    task automatic test_reset();
        RST_N = 1'b0; IN_VALID = 1'b0; IR_INPUT = 32'h0; OUT_READY = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset_outputs("reset_state");
        RST_N = 1'b1;
        q.delete();
    endtask

    // Single instruction with immediate consumption; also checks hand-derived constants.
    task automatic test_known(input logic [31:0] ir, input logic [31:0] e32, input logic [63:0] e64,
                              input logic [2:0] ef, input string name);
        step(1'b1, ir, 1'b1);
        total++;
        if (out_valid32 !== 1'b1 || imm32 !== e32 || imm64 !== e64 || fmt32 !== ef || fmt64 !== ef) begin
            bad++;
            $display("FAIL %s: got v=%b imm=%h imm64=%h fmt=%0d want imm=%h imm64=%h fmt=%0d",
                     name, out_valid32, imm32, imm64, fmt32, e32, e64, ef);
        end
        step(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_formats();
        test_known(32'hFFF00093, 32'hFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 3'd1, "addi_neg1");
        test_known(32'h123450B7, 32'h12345000, 64'h0000000012345000, 3'd4, "lui_pos");
        test_known(32'h800000B7, 32'h80000000, 64'hFFFFFFFF80000000, 3'd4, "lui_neg");
        test_known(32'hFE000EE3, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd3, "beq_m4");
        test_known(32'h00000033, 32'h0, 64'h0, 3'd0, "rtype");
        test_known(32'h34011073, 32'h340, 64'h340, 3'd1, "csrrw");
`ifdef IMM_GEN_ZIMM_EN
        test_known(32'h3402D073, 32'h5, 64'h5, 3'd6, "csrrwi_z");
`else
        test_known(32'h3402D073, 32'h340, 64'h340, 3'd1, "csrrwi_i");
`endif
        test_known(32'hFE112E23, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd2, "sw_m4");
        test_known(32'hFFDFF0EF, 32'hFFFFFFFC, 64'hFFFFFFFFFFFFFFFC, 3'd5, "jal_m4");
    endtask

    task automatic test_back_to_back();
        step(1'b1, 32'h00100093, 1'b0);
        step(1'b1, 32'h00200113, 1'b0);
        total++;
        if (in_ready32 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_full: got in_ready=%b want 0", in_ready32);
        end
        step(1'b1, 32'h00300193, 1'b0);
        step(1'b1, 32'h00300193, 1'b1);
        step(1'b1, 32'h00300193, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        step(1'b0, 32'h0, 1'b1);
        total++;
        if (q.size() != 0 || out_valid32 !== 1'b0) begin
            bad++;
            $display("FAIL b2b_drain: got pending=%0d out_valid=%b want 0 0", q.size(), out_valid32);
        end
    endtask

    task automatic test_random();
        logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73, 7'h7F};
        logic [31:0] ir;
        for (int i = 0; i < 600; i++) begin
            ir = $urandom;
            if ($urandom_range(0, 9) != 0) ir[6:0] = ops[$urandom_range(0, 10)];
            step(($urandom_range(0, 3) != 0), ir, ($urandom_range(0, 2) != 0));
        end
        for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    endtask

    task automatic test_reset_mid();
        step(1'b1, 32'hFFF00093, 1'b0);
        step(1'b1, 32'h800000B7, 1'b0);
        RST_N = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        check_reset_outputs("reset_mid_full");
        q.delete();
        RST_N = 1'b1;
        IN_VALID = 1'b0;
        step(1'b0, 32'h0, 1'b1);
    endtask

    initial begin
        test_reset();
        test_formats();
        test_back_to_back();
        test_random();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
